hs_stream_sink_checker: RTL



---
 rtl/hs_pkg.sv | 20 ++
 rtl/hs_bp_lfsr.sv | 38 +++
 rtl/hs_stream_sink_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// Shared types and constants for the valid/ready stream sink checker.
// Backpressure modes, FSM states and the backpressure LFSR polynomial.
package hs_pkg;

  localparam logic [1:0] BP_ALWAYS = 2'd0;
  localparam logic [1:0] BP_NEVER  = 2'd1;
  localparam logic [1:0] BP_TOGGLE = 2'd2;
  localparam logic [1:0] BP_LFSR   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/hs_bp_lfsr.sv
// Galois LFSR with load and step enables; a zero seed is remapped
// to a fixed non-zero value so the register never locks up.
module hs_bp_lfsr
  import hs_pkg::*;
#(
  parameter int W = 16,
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS),
  parameter logic [W-1:0] SEED_DEF = W'(LFSR_SEED)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         step_i,
  output logic         seed_bit_o,
  output logic [W-1:0] state_o,
  output logic [W-1:0] next_o
);

  logic [W-1:0] seed_eff;

  always_comb begin
    seed_eff = (seed_i == '0) ? SEED_DEF : seed_i;
    seed_bit_o = seed_eff[0];
    next_o = (state_o >> 1) ^ (state_o[0] ? TAPS : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_o <= '0;
    end else if (load_i) begin
      state_o <= seed_eff;
    end else if (step_i) begin
      state_o <= next_o;
    end
  end

endmodule

// File: rtl/hs_stream_sink_checker.sv
// Stream sink: drives patterned ready, checks an incrementing data
// sequence and upstream valid/data stability while stalled.
module hs_stream_sink_checker
  import hs_pkg::*;
#(
  parameter int DW = 8,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8,
  parameter int LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_pre_i,
  input  logic [DW-1:0]     data_pre_i,
  output logic              ready_pre_o,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [1:0]        bp_mode_i,
  input  logic [LFSR_W-1:0] bp_seed_i,
  input  logic [DW-1:0]     expect_start_i,
  input  logic [CNT_W-1:0]  num_beats_i,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic              data_err_o,
  output logic              proto_err_o,
  output logic [DW-1:0]     first_err_data_o,
  output logic              busy_o,
  output logic              done_o
);

  state_t state, next_state;

  logic [1:0]        mode;
  logic [DW-1:0]     exp_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  beat_inc;
  logic              phase;
  logic              stall;
  logic [DW-1:0]     stall_data;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
  logic              seed_bit;
  logic              run, start_ok, accept, last;
  logic              data_err, proto_err, pat;
  logic [ERR_W:0]    err_sum;

  hs_bp_lfsr #(
    .W(LFSR_W),
    .TAPS(LFSR_W'(LFSR_TAPS)),
    .SEED_DEF(LFSR_W'(LFSR_SEED))
  ) u_lfsr (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(start_ok),
    .seed_i(bp_seed_i),
    .step_i(run),
    .seed_bit_o(seed_bit),
    .state_o(lfsr_q),
    .next_o(lfsr_nxt)
  );

  always_comb begin
    run = (state == ST_RUN);
    start_ok = start_i && !clear_i && (state == ST_IDLE);
    accept = run && valid_pre_i && ready_pre_o;
    beat_inc = beat_cnt_o + 1'b1;
    last = accept && !clear_i && (beat_inc == num_q);
    data_err = accept && (data_pre_i != exp_q);
    // one protocol error per cycle, whether valid dropped or data moved
    proto_err = run && stall
      && (!valid_pre_i || (data_pre_i != stall_data));
    err_sum = {1'b0, err_cnt_o}
      + (ERR_W+1)'(data_err) + (ERR_W+1)'(proto_err);

    next_state = state;
    unique case (1'b1)
      clear_i:  next_state = ST_IDLE;
      start_ok: next_state = ST_RUN;
      last:     next_state = ST_DONE;
      default:  next_state = state;
    endcase

    pat = 1'b0;
    if (start_ok) begin
      unique case (bp_mode_i)
        BP_ALWAYS: pat = 1'b1;
        BP_NEVER:  pat = 1'b0;
        BP_TOGGLE: pat = 1'b1;
        BP_LFSR:   pat = seed_bit;
      endcase
    end else begin
      unique case (mode)
        BP_ALWAYS: pat = 1'b1;
        BP_NEVER:  pat = 1'b0;
        BP_TOGGLE: pat = ~phase;
        BP_LFSR:   pat = lfsr_nxt[0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ready_pre_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      mode <= BP_ALWAYS;
      exp_q <= '0;
      num_q <= '0;
      phase <= 1'b0;
      stall <= 1'b0;
      stall_data <= '0;
      beat_cnt_o <= '0;
      err_cnt_o <= '0;
      data_err_o <= 1'b0;
      proto_err_o <= 1'b0;
      first_err_data_o <= '0;
    end else begin
      state <= next_state;
      ready_pre_o <= (next_state == ST_RUN) && pat;
      busy_o <= (next_state == ST_RUN);
      done_o <= (next_state == ST_DONE);
      if (clear_i || start_ok) begin
        stall <= 1'b0;
        stall_data <= '0;
        beat_cnt_o <= '0;
        err_cnt_o <= '0;
        data_err_o <= 1'b0;
        proto_err_o <= 1'b0;
        first_err_data_o <= '0;
        if (start_ok) begin
          mode <= bp_mode_i;
          exp_q <= expect_start_i;
          num_q <= num_beats_i;
          phase <= 1'b1;
        end
      end else if (run) begin
        phase <= ~phase;
        stall <= valid_pre_i && !ready_pre_o;
        stall_data <= data_pre_i;
        if (accept) begin
          beat_cnt_o <= beat_inc;
          exp_q <= exp_q + 1'b1;
        end
        if (data_err) begin
          data_err_o <= 1'b1;
          if (!data_err_o) first_err_data_o <= data_pre_i;
        end
        if (proto_err) proto_err_o <= 1'b1;
        err_cnt_o <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      end
    end
  end

endmodule
